// File: rtl/thread_fetch_unit.sv
// Round-robin multithreaded fetch stage: one PC per thread, one imem read per cycle.
// Instruction, thread index, PC and valid line up on out_* one cycle after issue.
module thread_fetch_unit #(
  parameter int INSTR_WIDTH       = 32,
  parameter int THREAD_INDEX_BITS = 3,
  parameter int ADDR_WIDTH        = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [(2**THREAD_INDEX_BITS)-1:0] thread_enable,
  input  logic                              stall,
  input  logic                              redirect_valid,
  input  logic [THREAD_INDEX_BITS-1:0]      redirect_thread,
  input  logic [ADDR_WIDTH-1:0]             redirect_pc,
  output logic                              imem_req,
  output logic [ADDR_WIDTH-1:0]             imem_addr,
  input  logic [INSTR_WIDTH-1:0]            imem_rdata,
  output logic [INSTR_WIDTH-1:0]            out_instruction,
  output logic [THREAD_INDEX_BITS-1:0]      out_thread_index,
  output logic [ADDR_WIDTH-1:0]             out_pc,
  output logic                              out_valid
);

  localparam int NUM_THREADS = 2**THREAD_INDEX_BITS;

  logic [ADDR_WIDTH-1:0]        pc [NUM_THREADS];
  logic [THREAD_INDEX_BITS-1:0] last;
  logic [THREAD_INDEX_BITS-1:0] sel;
  logic [THREAD_INDEX_BITS-1:0] cand;
  logic                         found;
  logic                         any_en;

  // Scan starts just after the last issued thread; i == NUM_THREADS wraps back to last itself.
  always_comb begin
    sel   = last;
    cand  = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      cand = last + THREAD_INDEX_BITS'(i);
      if (!found && thread_enable[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign any_en          = |thread_enable;
  assign imem_req        = !reset && !stall && any_en;
  assign imem_addr       = pc[sel];
  assign out_instruction = imem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc[t] <= RESET_PC;
      end
      last             <= THREAD_INDEX_BITS'(NUM_THREADS - 1);
      out_valid        <= 1'b0;
      out_thread_index <= '0;
      out_pc           <= '0;
    end else begin
      if (imem_req) begin
        last             <= sel;
        pc[sel]          <= pc[sel] + ADDR_WIDTH'(4);
        out_thread_index <= sel;
        out_pc           <= pc[sel];
        out_valid        <= !(redirect_valid && (redirect_thread == sel));
      end else if (!stall) begin
        out_valid <= 1'b0;
      end
      // Later assignment wins, so a redirect overrides the +4 of a same-thread issue.
      if (redirect_valid) begin
        pc[redirect_thread] <= redirect_pc;
      end
    end
  end

endmodule

// File: tb/tb_thread_fetch_unit.sv
// Directed bench for thread_fetch_unit: default instance plus a RESET_PC wrap instance.
module tb_thread_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, redirect_valid;
  logic [7:0]  thread_enable;
  logic [2:0]  redirect_thread;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, out_instruction, out_pc;
  logic [2:0]  out_thread_index;
  logic        out_valid;

  logic        reset2;
  logic [7:0]  thread_enable2;
  logic        imem_req2;
  logic [31:0] imem_addr2, imem_rdata2, out_instruction2, out_pc2;
  logic [2:0]  out_thread_index2;
  logic        out_valid2;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  initial imem_rdata = '0;
  always @(posedge clk) if (imem_req) imem_rdata <= memf(imem_addr);
  initial imem_rdata2 = '0;
  always @(posedge clk) if (imem_req2) imem_rdata2 <= memf(imem_addr2);

  thread_fetch_unit dut (
    .clk(clk), .reset(reset), .thread_enable(thread_enable), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_thread(redirect_thread), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_instruction(out_instruction), .out_thread_index(out_thread_index),
    .out_pc(out_pc), .out_valid(out_valid)
  );

  thread_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset2), .thread_enable(thread_enable2), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_thread(3'd0), .redirect_pc(32'd0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .out_instruction(out_instruction2), .out_thread_index(out_thread_index2),
    .out_pc(out_pc2), .out_valid(out_valid2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] idx, input logic [31:0] pcv, input logic v);
    chk({tag, " idx"}, 64'(out_thread_index), 64'(idx));
    chk({tag, " pc"}, 64'(out_pc), 64'(pcv));
    chk({tag, " valid"}, 64'(out_valid), 64'(v));
    chk({tag, " instr"}, 64'(out_instruction), 64'(memf(pcv)));
  endtask

  logic [2:0]  t2_idx [4];
  logic [31:0] t2_pc  [4];

  initial begin
    t2_idx = '{3'd2, 3'd0, 3'd2, 3'd0};
    t2_pc  = '{32'h8, 32'h8, 32'hC, 32'hC};
    t2_pc[0] = 32'h4;
    t2_pc[3] = 32'hC;
    t2_pc[2] = 32'h8;
    t2_pc[1] = 32'h8;

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_thread = '0; redirect_pc = '0;
    thread_enable = 8'hFF;
    reset2 = 1'b1; thread_enable2 = 8'h01;
    #1;
    chk("req_in_reset", 64'(imem_req), 64'd0);
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_idx", 64'(out_thread_index), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);

    // Test 1: all threads round-robin
    reset = 1'b0;
    #1;
    chk("t1_req", 64'(imem_req), 64'd1);
    chk("t1_addr", 64'(imem_addr), 64'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk_out("t1", 3'(i % 8), (i == 8) ? 32'h4 : 32'h0, 1'b1);
    end

    // Test 2: threads 0 and 2 alternate (t0 pc=8, t2 pc=4, last=0)
    thread_enable = 8'b0000_0101;
    for (int j = 0; j < 4; j++) begin
      step();
      chk_out("t2", t2_idx[j], t2_pc[j], 1'b1);
    end

    // Test 3: stall 3 cycles (t0 pc=16, t2 pc=12, last=0)
    stall = 1'b1;
    #1;
    chk("t3_req", 64'(imem_req), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out("t3_hold", 3'd0, 32'hC, 1'b1);
    end
    stall = 1'b0;
    step();
    chk_out("t3_resume_a", 3'd2, 32'hC, 1'b1);
    step();
    chk_out("t3_resume_b", 3'd0, 32'h10, 1'b1);

    // Test 4: redirect thread 1 in its own issue cycle (t1 pc=4)
    thread_enable = 8'hFF;
    redirect_valid = 1'b1; redirect_thread = 3'd1; redirect_pc = 32'h100;
    #1;
    chk("t4_addr", 64'(imem_addr), 64'h4);
    step();
    redirect_valid = 1'b0;
    chk("t4_sq_valid", 64'(out_valid), 64'd0);
    chk("t4_sq_idx", 64'(out_thread_index), 64'd1);
    chk("t4_sq_pc", 64'(out_pc), 64'h4);
    thread_enable = 8'b0000_0010;
    #1;
    chk("t4_new_addr", 64'(imem_addr), 64'h100);
    step();
    chk_out("t4_new", 3'd1, 32'h100, 1'b1);

    // Test 6: no thread enabled, then reset during fetch (t2 pc=16, last=1)
    thread_enable = 8'h00;
    #1;
    chk("t6_req_idle", 64'(imem_req), 64'd0);
    step();
    chk("t6_idle_valid", 64'(out_valid), 64'd0);
    step();
    chk("t6_idle_valid2", 64'(out_valid), 64'd0);
    thread_enable = 8'hFF;
    step();
    chk_out("t6_resume", 3'd2, 32'h10, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_req_rst", 64'(imem_req), 64'd0);
    step();
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_idx", 64'(out_thread_index), 64'd0);
    chk("t6_rst_pc", 64'(out_pc), 64'd0);
    reset = 1'b0;
    #1;
    chk("t6_addr", 64'(imem_addr), 64'd0);
    step();
    chk_out("t6_after", 3'd0, 32'h0, 1'b1);

    // Test 5: PC wrap on the RESET_PC=0xFFFFFFFC instance
    reset2 = 1'b0;
    #1;
    chk("t5_addr", 64'(imem_addr2), 64'hFFFF_FFFC);
    step();
    chk("t5_pc_a", 64'(out_pc2), 64'hFFFF_FFFC);
    chk("t5_valid_a", 64'(out_valid2), 64'd1);
    chk("t5_instr_a", 64'(out_instruction2), 64'(memf(32'hFFFF_FFFC)));
    step();
    chk("t5_pc_b", 64'(out_pc2), 64'h0);
    chk("t5_idx_b", 64'(out_thread_index2), 64'd0);
    chk("t5_instr_b", 64'(out_instruction2), 64'(memf(32'h0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
